seg_frame_decoder: RTL and testbench

Receive-side counterpart of the multiplexed seven-segment display driver. Monitors the 12-bit multiplexed `segs` bus, waits for each digit slot to settle, and decodes each glyph back to a 4-bit value. Collects one value per digit into a frame and publishes complete frames with a one-cycle strobe. Used as a board-level self-check and as the scoreboard front end in the display testbench.

---
 rtl/seg_pkg.sv | 70 +++++++
 rtl/seg_glyph_decode.sv | 19 +
 rtl/seg_frame_decoder.sv | 127 ++++++++++++
 tb/tb_seg_frame_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment frame decoder: bus fields, glyphs, FSM states.
// Build with SEG_HEX_EN defined to also accept the hex glyphs A..F.
package seg_pkg;

    localparam int SEG_W   = 12;
    localparam int EN_HI   = 11;
    localparam int EN_LO   = 8;
    localparam int DP_BIT  = 7;
    localparam int SEG_HI  = 6;
    localparam int SEG_LO  = 0;

    // Active-high g..a patterns.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    typedef struct packed {
        logic       err;
        logic [3:0] val;
    } glyph_res_t;

    function automatic glyph_res_t glyph_decode(input logic [6:0] pat);
        glyph_res_t r;
        r.err = 1'b0;
        r.val = 4'd0;
        case (pat)
            GLYPH_0: r.val = 4'd0;
            GLYPH_1: r.val = 4'd1;
            GLYPH_2: r.val = 4'd2;
            GLYPH_3: r.val = 4'd3;
            GLYPH_4: r.val = 4'd4;
            GLYPH_5: r.val = 4'd5;
            GLYPH_6: r.val = 4'd6;
            GLYPH_7: r.val = 4'd7;
            GLYPH_8: r.val = 4'd8;
            GLYPH_9: r.val = 4'd9;
`ifdef SEG_HEX_EN
            GLYPH_A: r.val = 4'd10;
            GLYPH_B: r.val = 4'd11;
            GLYPH_C: r.val = 4'd12;
            GLYPH_D: r.val = 4'd13;
            GLYPH_E: r.val = 4'd14;
            GLYPH_F: r.val = 4'd15;
`endif
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: active-high g..a pattern to 4-bit value plus error flag.
// Hex glyphs are accepted only when SEG_HEX_EN is defined.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] value_o,
    output logic       err_o
);

    glyph_res_t res;

    always_comb begin
        res     = glyph_decode(pattern_i);
        value_o = res.val;
        err_o   = res.err;
    end

endmodule

// File: rtl/seg_frame_decoder.sv
// Watches the multiplexed active-low seven-segment bus, captures each settled digit
// and publishes complete 4-digit frames. SEG_HEX_EN enables hex glyph decoding.
module seg_frame_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] segs,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic        frame_valid,
    output logic [3:0]  glyph_err,
    output logic        busy,
    output logic [1:0]  dbg_state_o,
    output logic [3:0]  dbg_seen_o
);

    logic [11:0] sync1_q, sync2_q, latch_q;
    logic [7:0]  cnt_q;
    state_e      state_q;
    logic [15:0] buf_q, digits_q;
    logic [3:0]  dpbuf_q, dps_q, seen_q, seen_d, err_q, cap_sel;
    logic        frame_done_q, frame_valid_q, busy_q, en_ok, dec_err;
    logic [3:0]  dec_val;

    assign en_ok   = $onehot(~sync2_q[EN_HI:EN_LO]);
    assign cap_sel = ~latch_q[EN_HI:EN_LO];

    seg_glyph_decode u_dec (
        .pattern_i (~latch_q[SEG_HI:SEG_LO]),
        .value_o   (dec_val),
        .err_o     (dec_err)
    );

    // A capture on the publish edge must survive the clear of the completed frame.
    always_comb begin
        seen_d = frame_done_q ? 4'b0000 : seen_q;
        if (state_q == CAPTURE) seen_d = seen_d | cap_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            latch_q       <= '1;
            cnt_q         <= '0;
            state_q       <= IDLE;
            buf_q         <= '0;
            dpbuf_q       <= '0;
            seen_q        <= '0;
            frame_done_q  <= 1'b0;
            digits_q      <= '0;
            dps_q         <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= '0;
            busy_q        <= 1'b0;
        end else begin
            sync1_q       <= segs;
            sync2_q       <= sync1_q;
            seen_q        <= seen_d;
            frame_done_q  <= (state_q == CAPTURE) && (seen_d == 4'b1111);
            frame_valid_q <= frame_done_q;
            if (frame_done_q) begin
                digits_q <= buf_q;
                dps_q    <= dpbuf_q;
            end
            case (state_q)
                IDLE: begin
                    if (en_ok) begin
                        state_q <= SETTLE;
                        busy_q  <= 1'b1;
                        cnt_q   <= 8'd1;
                        latch_q <= sync2_q;
                    end
                end
                SETTLE: begin
                    if (!en_ok) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (sync2_q != latch_q) begin
                        cnt_q   <= 8'd1;
                        latch_q <= sync2_q;
                    end else if (cnt_q >= 8'(SETTLE_CYCLES)) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                CAPTURE: begin
                    for (int i = 0; i < 4; i++) begin
                        if (cap_sel[i]) begin
                            buf_q[4*i +: 4] <= dec_val;
                            dpbuf_q[i]      <= ~latch_q[DP_BIT];
                            if (dec_err) err_q[i] <= 1'b1;
                        end
                    end
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (sync2_q != latch_q) begin
                        if (en_ok) begin
                            state_q <= SETTLE;
                            busy_q  <= 1'b1;
                            cnt_q   <= 8'd1;
                            latch_q <= sync2_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign digits      = digits_q;
    assign dps         = dps_q;
    assign frame_valid = frame_valid_q;
    assign glyph_err   = err_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;
    assign dbg_seen_o  = seen_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Self-checking bench for seg_frame_decoder: drives frames on the multiplexed bus and
// scores published frames against an expected queue.
module tb_seg_frame_decoder;

    logic        clk;
    logic        reset;
    logic [11:0] segs;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic        frame_valid;
    logic [3:0]  glyph_err;
    logic        busy;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_seen;

    localparam logic [1:0] ST_IDLE = 2'd0;

    int n_cmp = 0;
    int n_err = 0;
    int n_frames = 0;
    logic [23:0] exp_q[$];
    logic [3:0]  exp_err_acc = 4'b0000;

    seg_frame_decoder #(.SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .segs        (segs),
        .digits      (digits),
        .dps         (dps),
        .frame_valid (frame_valid),
        .glyph_err   (glyph_err),
        .busy        (busy),
        .dbg_state_o (dbg_state),
        .dbg_seen_o  (dbg_seen)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference glyph table: returns {err, value}.
    function automatic logic [4:0] ref_decode(input logic [6:0] g);
        case (g)
            7'h3F: return 5'h00;
            7'h06: return 5'h01;
            7'h5B: return 5'h02;
            7'h4F: return 5'h03;
            7'h66: return 5'h04;
            7'h6D: return 5'h05;
            7'h7D: return 5'h06;
            7'h07: return 5'h07;
            7'h7F: return 5'h08;
            7'h6F: return 5'h09;
`ifdef SEG_HEX_EN
            7'h77: return 5'h0A;
            7'h7C: return 5'h0B;
            7'h39: return 5'h0C;
            7'h5E: return 5'h0D;
            7'h79: return 5'h0E;
            7'h71: return 5'h0F;
`endif
            default: return 5'h10;
        endcase
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset && frame_valid) begin
            n_frames++;
            if (exp_q.size() == 0) check_eq("unexpected_frame", 32'd1, 32'd0);
            else check_eq("frame", {8'h00, glyph_err, dps, digits}, {8'h00, exp_q.pop_front()});
        end
    end

    // Drivers
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int idx, input logic [6:0] g, input logic dp, input int hold);
        logic [3:0] en_n;
        en_n = ~(4'b0001 << idx);
        segs = {en_n, ~dp, ~g};
        step(hold);
    endtask

    task automatic drive_frame(input logic [27:0] g, input logic [3:0] dp);
        logic [15:0] exp_dig;
        logic [4:0]  r;
        exp_dig = '0;
        for (int i = 0; i < 4; i++) begin
            r = ref_decode(g[7*i +: 7]);
            exp_dig[4*i +: 4] = r[3:0];
            if (r[4]) exp_err_acc[i] = 1'b1;
        end
        exp_q.push_back({exp_err_acc, dp, exp_dig});
        for (int i = 0; i < 4; i++) drive_digit(i, g[7*i +: 7], dp[i], 10);
        segs = 12'hFFF;
        step(4);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        int f0;
        reset = 1'b0;
        segs  = 12'hFFF;
        step(3);
        @(negedge clk);
        check_eq("rst_digits", digits, 0);
        check_eq("rst_dps", dps, 0);
        check_eq("rst_fv", frame_valid, 0);
        check_eq("rst_err", glyph_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);
        check_eq("rst_seen", dbg_seen, 0);
        step(1);
        reset = 1'b1;
        step(3);

        // Basic frame: digits 2,3,4,1 -> 16'h1432
        drive_frame({7'h06, 7'h66, 7'h4F, 7'h5B}, 4'b0000);
        wait_drain("drain_basic");
        check_eq("basic_digits", digits, 16'h1432);
        check_eq("basic_err", glyph_err, 4'b0000);

        // Unstable bus: segment bit toggles every 2 cycles on digit 0
        f0 = n_frames;
        segs = {4'b1110, 1'b1, ~7'h06};
        for (int i = 0; i < 30; i++) begin
            if (i > 0 && i % 2 == 0) segs[0] = ~segs[0];
            step(1);
            @(negedge clk);
            if (i >= 4) check_eq("toggle_busy", busy, 1);
        end
        check_eq("toggle_seen", dbg_seen, 4'b0000);
        check_eq("toggle_no_frame", n_frames - f0, 0);
        segs = 12'hFFF;
        step(5);

        // Two enables low together: invalid enable word
        f0 = n_frames;
        segs = {4'b1100, 1'b1, ~7'h3F};
        for (int i = 0; i < 20; i++) begin
            step(1);
            @(negedge clk);
            if (i % 4 == 3) begin
                check_eq("dual_en_state", dbg_state, ST_IDLE);
                check_eq("dual_en_seen", dbg_seen, 4'b0000);
            end
        end
        check_eq("dual_en_no_frame", n_frames - f0, 0);
        segs = 12'hFFF;
        step(4);

        // Hex glyph on digit 2
        drive_frame({7'h4F, 7'h77, 7'h06, 7'h3F}, 4'b0000);
        wait_drain("drain_hex");
`ifdef SEG_HEX_EN
        check_eq("hex_err", glyph_err, 4'b0000);
        check_eq("hex_nibble2", digits[11:8], 4'hA);
`else
        check_eq("hex_err", glyph_err, 4'b0100);
        check_eq("hex_nibble2", digits[11:8], 4'h0);
`endif

        // Decimal point on digit 3 only
        drive_frame({7'h7F, 7'h07, 7'h7D, 7'h6D}, 4'b1000);
        wait_drain("drain_dp");
        check_eq("dp_dps", dps, 4'b1000);
        check_eq("dp_digits", digits, 16'h8765);

        // Partial frame, then reset mid-frame
        for (int i = 0; i < 3; i++) drive_digit(i, 7'h3F, 1'b0, 10);
        @(negedge clk);
        check_eq("partial_seen", dbg_seen, 4'b0111);
        step(1);
        reset = 1'b0;
        segs  = 12'hFFF;
        exp_err_acc = 4'b0000;
        #2;
        check_eq("midrst_digits", digits, 0);
        check_eq("midrst_dps", dps, 0);
        check_eq("midrst_fv", frame_valid, 0);
        check_eq("midrst_err", glyph_err, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_seen", dbg_seen, 0);
        check_eq("midrst_state", dbg_state, ST_IDLE);
        step(3);
        reset = 1'b1;
        step(3);
        f0 = n_frames;
        drive_frame({7'h66, 7'h4F, 7'h5B, 7'h6F}, 4'b0000);
        wait_drain("drain_fresh");
        check_eq("fresh_one_frame", n_frames - f0, 1);
        check_eq("fresh_digits", digits, 16'h4329);

        step(5);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
